// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared constants for the pipelined datapath. Holds the
//               default data/register-file sizes and the 4-bit ALU opcodes
//               produced by the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/datapath_regfile.sv
`default_nettype none
// ============================================================================
// Module      : datapath_regfile
// Description : NUM_REGS x XLEN register file. Two read ports and one debug
//               read port, one write port. Entry 0 always reads zero and
//               ignores writes. Both operand read ports are write-first: a
//               write landing on the same edge is visible to the reader.
// Ports       : clock, reset (async active-low)
//               we, waddr, wdata            write port
//               raddr1/rdata1, raddr2/rdata2 operand read ports (bypassed)
//               dbg_addr/dbg_data           debug read port (array only)
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [XLEN-1:0]   rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]   rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic            wr_live;

  // A write to x0 is discarded here, so nothing downstream needs to care.
  assign wr_live = we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-first: the value being written this edge wins over the stored one.
  assign rdata1   = (wr_live && (waddr == raddr1)) ? wdata : regs_q[raddr1];
  assign rdata2   = (wr_live && (waddr == raddr2)) ? wdata : regs_q[raddr2];
  assign dbg_data = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/pipelined_datapath.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_datapath
// Description : Two-stage (ID/EX, EX/WB) register-file + ALU datapath.
//               Operands are resolved at issue: x0 -> 0, optional EX-stage
//               forward of the live ALU result, write-first bypass from the
//               writeback stage, otherwise the register file. Results appear
//               on wb_* two clocks after issue and are written back on the
//               following edge.
// Config      : DATAPATH_FORWARD_EN - when defined, adds the EX->ID forward so
//               distance-1 dependencies need no stall.
// Ports       : clock, reset (async active-low)
//               in_valid, rs1, rs2, rd, imm, alu_src_imm,
//               alu_control_signal, regwrite_control_signal  issue fields
//               out_valid, wb_rd, wb_data, zero_flag         EX/WB result
//               dbg_addr, dbg_data                           debug read
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter  int XLEN       = XLEN_DEFAULT,
  parameter  int NUM_REGS   = NUM_REGS_DEFAULT,
  localparam int REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       imm,
  input  logic                  alu_src_imm,
  input  logic [3:0]            alu_control_signal,
  input  logic                  regwrite_control_signal,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  zero_flag,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  localparam int SHAMT_W = $clog2(XLEN);

  // ID/EX stage
  logic                  idex_valid_q,    idex_valid_d;
  logic                  idex_regwrite_q, idex_regwrite_d;
  logic [REG_ADDR_W-1:0] idex_rd_q,       idex_rd_d;
  logic [3:0]            idex_op_q,       idex_op_d;
  logic [XLEN-1:0]       idex_a_q,        idex_a_d;
  logic [XLEN-1:0]       idex_b_q,        idex_b_d;

  // EX/WB stage
  logic                  exwb_valid_q,    exwb_valid_d;
  logic                  exwb_regwrite_q, exwb_regwrite_d;
  logic [REG_ADDR_W-1:0] exwb_rd_q,       exwb_rd_d;
  logic [XLEN-1:0]       exwb_data_q,     exwb_data_d;
  logic                  zero_q,          zero_d;

  logic [XLEN-1:0]       rf_rdata1;
  logic [XLEN-1:0]       rf_rdata2;
  logic [XLEN-1:0]       op_a;
  logic [XLEN-1:0]       op_b_reg;
  logic [XLEN-1:0]       alu_result;
  logic [SHAMT_W-1:0]    shamt;

  // --------------------------------------------------------------------------
  // Register file; the WB-stage bypass lives inside its read ports.
  // --------------------------------------------------------------------------
  datapath_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (REG_ADDR_W)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .we       (exwb_valid_q && exwb_regwrite_q),
    .waddr    (exwb_rd_q),
    .wdata    (exwb_data_q),
    .raddr1   (rs1),
    .rdata1   (rf_rdata1),
    .raddr2   (rs2),
    .rdata2   (rf_rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // --------------------------------------------------------------------------
  // ALU on the ID/EX operands
  // --------------------------------------------------------------------------
  assign shamt = idex_b_q[SHAMT_W-1:0];

  always_comb begin
    alu_result = '0;
    case (idex_op_q)
      ALU_AND: alu_result = idex_a_q & idex_b_q;
      ALU_OR:  alu_result = idex_a_q | idex_b_q;
      ALU_ADD: alu_result = idex_a_q + idex_b_q;
      ALU_SUB: alu_result = idex_a_q - idex_b_q;
      ALU_XOR: alu_result = idex_a_q ^ idex_b_q;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(idex_a_q) < $signed(idex_b_q))};
      ALU_SLL: alu_result = idex_a_q << shamt;
      ALU_SRL: alu_result = idex_a_q >> shamt;
      ALU_SRA: alu_result = $unsigned($signed(idex_a_q) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand resolution. Later assignments override earlier ones, so the
  // statement order below runs lowest priority first.
  // --------------------------------------------------------------------------
`ifdef DATAPATH_FORWARD_EN
  logic ex_can_fwd;
  assign ex_can_fwd = idex_valid_q && idex_regwrite_q && (idex_rd_q != '0);
`endif

  always_comb begin
    op_a     = rf_rdata1;
    op_b_reg = rf_rdata2;
`ifdef DATAPATH_FORWARD_EN
    if (ex_can_fwd && (idex_rd_q == rs1)) op_a     = alu_result;
    if (ex_can_fwd && (idex_rd_q == rs2)) op_b_reg = alu_result;
`endif
    if (rs1 == '0) op_a     = '0;
    if (rs2 == '0) op_b_reg = '0;
  end

  // --------------------------------------------------------------------------
  // Next-state for both pipeline stages
  // --------------------------------------------------------------------------
  always_comb begin
    idex_valid_d    = in_valid;
    idex_regwrite_d = in_valid && regwrite_control_signal;
    idex_rd_d       = rd;
    idex_op_d       = alu_control_signal;
    idex_a_d        = op_a;
    idex_b_d        = alu_src_imm ? imm : op_b_reg;

    exwb_valid_d    = idex_valid_q;
    exwb_regwrite_d = idex_regwrite_q;
    exwb_rd_d       = idex_rd_q;
    exwb_data_d     = alu_result;
    zero_d          = (alu_result == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idex_valid_q    <= 1'b0;
      idex_regwrite_q <= 1'b0;
      idex_rd_q       <= '0;
      idex_op_q       <= '0;
      idex_a_q        <= '0;
      idex_b_q        <= '0;
      exwb_valid_q    <= 1'b0;
      exwb_regwrite_q <= 1'b0;
      exwb_rd_q       <= '0;
      exwb_data_q     <= '0;
      zero_q          <= 1'b1;
    end else begin
      idex_valid_q    <= idex_valid_d;
      idex_regwrite_q <= idex_regwrite_d;
      idex_rd_q       <= idex_rd_d;
      idex_op_q       <= idex_op_d;
      idex_a_q        <= idex_a_d;
      idex_b_q        <= idex_b_d;
      exwb_valid_q    <= exwb_valid_d;
      exwb_regwrite_q <= exwb_regwrite_d;
      exwb_rd_q       <= exwb_rd_d;
      exwb_data_q     <= exwb_data_d;
      zero_q          <= zero_d;
    end
  end

  assign out_valid = exwb_valid_q;
  assign wb_rd     = exwb_rd_q;
  assign wb_data   = exwb_data_q;
  assign zero_flag = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_datapath
// Description : Directed self-checking bench for pipelined_datapath. Inputs
//               change 1 ns after a rising edge; outputs are sampled there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_datapath;
  import datapath_pkg::*;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        alu_src_imm;
  logic [3:0]  alu_control_signal;
  logic        regwrite_control_signal;
  logic        out_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        zero_flag;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

`ifdef DATAPATH_FORWARD_EN
  localparam logic [31:0] EXP_DIST1 = 32'd14;
`else
  localparam logic [31:0] EXP_DIST1 = 32'd0;
`endif

  // ALU sweep with A = x1 = 0x80000000 and B = imm
  logic [3:0]  v_op  [10] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR,
                              ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, 4'b1111};
  logic [31:0] v_imm [10] = '{32'hFFFF_0000, 32'h0000_000F, 32'h8000_0000, 32'h0000_0001,
                              32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0021, 32'h0000_001F,
                              32'h0000_0004, 32'h0000_0005};
  logic [31:0] v_exp [10] = '{32'h8000_0000, 32'h8000_000F, 32'h0000_0000, 32'h7FFF_FFFF,
                              32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001,
                              32'hF800_0000, 32'h0000_0000};

  pipelined_datapath dut (
    .clock                   (clock),
    .reset                   (reset),
    .in_valid                (in_valid),
    .rs1                     (rs1),
    .rs2                     (rs2),
    .rd                      (rd),
    .imm                     (imm),
    .alu_src_imm             (alu_src_imm),
    .alu_control_signal      (alu_control_signal),
    .regwrite_control_signal (regwrite_control_signal),
    .out_valid               (out_valid),
    .wb_rd                   (wb_rd),
    .wb_data                 (wb_data),
    .zero_flag               (zero_flag),
    .dbg_addr                (dbg_addr),
    .dbg_data                (dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input logic [31:0] im, input logic si,
                       input logic [3:0] op, input logic rw);
    in_valid                = v;
    rs1                     = r1;
    rs2                     = r2;
    rd                      = d;
    imm                     = im;
    alu_src_imm             = si;
    alu_control_signal      = op;
    regwrite_control_signal = rw;
  endtask

  task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] d, input logic [31:0] im, input logic si,
                      input logic [3:0] op, input logic rw);
    drive(v, r1, r2, d, im, si, op, rw);
    @(posedge clock);
    #1;
  endtask

  task automatic bubble();
    step(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    reset    = 1'b0;
    dbg_addr = 5'd0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0);

    // ---- 1. reset state, then reset with two ops in flight ----
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_wb_data",   wb_data,   32'd0);
    chk("rst_wb_rd",     wb_rd,     32'd0);
    chk("rst_zero_flag", zero_flag, 32'd1);
    reset = 1'b1;
    step(1'b1, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, ALU_ADD, 1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd2, 32'd3, 1'b1, ALU_ADD, 1'b1);
    chk("pre_midrst_wb_data", wb_data, 32'd5);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 32'd0);
    chk("midrst_wb_data",   wb_data,   32'd0);
    chk("midrst_zero_flag", zero_flag, 32'd1);
    @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg_chk($sformatf("midrst_dbg_x%0d", i), 5'(i), 32'd0);
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    bubble();
    bubble();
    chk("postrst_out_valid", out_valid, 32'd0);
    dbg_chk("postrst_dbg_x1", 5'd1, 32'd0);
    dbg_chk("postrst_dbg_x2", 5'd2, 32'd0);

    // ---- 2. x1=5, x2=3, two bubbles, SUB x3=x1-x2 ----
    step(1'b1, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, ALU_ADD, 1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd2, 32'd3, 1'b1, ALU_ADD, 1'b1);
    chk("ld_x1_wb_data", wb_data, 32'd5);
    chk("ld_x1_wb_rd",   wb_rd,   32'd1);
    bubble();
    chk("ld_x2_wb_data", wb_data, 32'd3);
    bubble();
    chk("bubble_out_valid", out_valid, 32'd0);
    step(1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, ALU_SUB, 1'b1);
    bubble();
    chk("sub_out_valid", out_valid, 32'd1);
    chk("sub_wb_data",   wb_data,   32'd2);
    chk("sub_zero_flag", zero_flag, 32'd0);
    chk("sub_wb_rd",     wb_rd,     32'd3);
    bubble();
    dbg_chk("sub_dbg_x3", 5'd3, 32'd2);

    // ---- 3. distance-1 dependency from a clean register file ----
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step(1'b1, 5'd0, 5'd0, 5'd1, 32'd7, 1'b1, ALU_ADD, 1'b1);
    step(1'b1, 5'd1, 5'd1, 5'd4, 32'd0, 1'b0, ALU_ADD, 1'b1);
    chk("dist1_producer", wb_data, 32'd7);
    bubble();
    chk("dist1_wb_data", wb_data, EXP_DIST1);

    // ---- 4. distance-2 dependency through the write-first bypass ----
    step(1'b1, 5'd0, 5'd0, 5'd1, 32'd9, 1'b1, ALU_ADD, 1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd2, 32'd1, 1'b1, ALU_ADD, 1'b1);
    step(1'b1, 5'd1, 5'd1, 5'd5, 32'd0, 1'b0, ALU_ADD, 1'b1);
    bubble();
    chk("dist2_wb_data", wb_data, 32'd18);
    chk("dist2_wb_rd",   wb_rd,   32'd5);

    // ---- 5. write to x0 is reported but never stored or forwarded ----
    step(1'b1, 5'd0, 5'd0, 5'd0, 32'd42, 1'b1, ALU_ADD, 1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd6, 32'd0, 1'b0, ALU_ADD, 1'b1);
    chk("x0w_out_valid", out_valid, 32'd1);
    chk("x0w_wb_data",   wb_data,   32'd42);
    chk("x0w_wb_rd",     wb_rd,     32'd0);
    bubble();
    chk("x0r_wb_data",   wb_data,   32'd0);
    chk("x0r_zero_flag", zero_flag, 32'd1);
    dbg_chk("x0_dbg", 5'd0, 32'd0);

    // ---- 6. ALU sweep with x1 = 0x80000000, results pipelined ----
    step(1'b1, 5'd0, 5'd0, 5'd1, 32'h8000_0000, 1'b1, ALU_ADD, 1'b1);
    bubble();
    bubble();
    dbg_chk("sweep_dbg_x1", 5'd1, 32'h8000_0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'd1, 5'd0, 5'd10, v_imm[i], 1'b1, v_op[i], 1'b0);
      if (i > 0) begin
        chk($sformatf("alu%0d_data", i - 1), wb_data, v_exp[i-1]);
        chk($sformatf("alu%0d_zero", i - 1), zero_flag, {31'd0, (v_exp[i-1] == 32'd0)});
      end
    end
    bubble();
    chk("alu9_data",      wb_data,   v_exp[9]);
    chk("alu9_zero",      zero_flag, 32'd1);
    chk("alu9_out_valid", out_valid, 32'd1);
    bubble();
    chk("tail_out_valid", out_valid, 32'd0);
    dbg_chk("sweep_nowrite_x10", 5'd10, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
